nrzi_frame_receiver: RTL

//   Receive end of the toggle-encoded serial link. The transmit end drives the line from a T flip-flop:
//   a '1' bit toggles the line level and a '0' bit holds it.

---
 rtl/nrzi_frame_receiver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nrzi_frame_receiver.sv
// Toggle-encoded serial receiver: recovers bits by XOR with the previous level, hunts for a
// sync word, deserialises LSB-first words and offers them on a valid/ready port.
module nrzi_frame_receiver #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC      = SYNC_W'(8'h7E),
  parameter int unsigned       IDLE_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              line_in,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              in_frame,
  output logic              overflow
);

  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned ZeroW = $clog2(IDLE_BITS + 1);

  typedef enum logic [0:0] {StHunt, StData} state_e;

  state_e              state_q, state_d;
  logic                prev_q, prev_d;
  logic [SYNC_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ZeroW-1:0]    zero_cnt_q, zero_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  logic                dec;
  logic                word_done;
  logic                ovf_set;
  logic                last_bit;
  logic [DATA_W-1:0]   word;
  logic [ZeroW-1:0]    zero_next;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    sr_d       = sr_q;
    asm_d      = asm_q;
    bit_cnt_d  = bit_cnt_q;
    zero_cnt_d = zero_cnt_q;
    word_done  = 1'b0;
    dec        = line_in ^ prev_q;
    word       = {dec, asm_q[DATA_W-1:1]};
    last_bit   = (bit_cnt_q == CntW'(DATA_W - 1));
    zero_next  = dec ? '0 : zero_cnt_q + 1'b1;

    if (bit_en) begin
      prev_d = line_in;
      unique case (state_q)
        StHunt: begin
          sr_d = {dec, sr_q[SYNC_W-1:1]};
          if ({dec, sr_q[SYNC_W-1:1]} == SYNC) begin
            state_d    = StData;
            asm_d      = '0;
            bit_cnt_d  = '0;
            zero_cnt_d = '0;
          end
        end
        StData: begin
          asm_d      = word;
          zero_cnt_d = zero_next;
          bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
          // Idle abort takes priority over a word finishing on the same bit.
          if (zero_next == ZeroW'(IDLE_BITS)) begin
            state_d    = StHunt;
            sr_d       = '0;
            asm_d      = '0;
            bit_cnt_d  = '0;
            zero_cnt_d = '0;
          end else if (last_bit) begin
            word_done = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    ovf_set = word_done && valid_q && !out_ready;
    if (word_done && !ovf_set) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StHunt;
      prev_q     <= 1'b1;
      sr_q       <= '0;
      asm_q      <= '0;
      bit_cnt_q  <= '0;
      zero_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sr_q       <= sr_d;
      asm_q      <= asm_d;
      bit_cnt_q  <= bit_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign in_frame   = (state_q == StData);
  assign overflow   = ovf_q;

endmodule
